ft245_axis_deframer: RTL and testbench
======================================

# ft245_axis_deframer

Length-delimited frame decoder that sits directly downstream of the FT245 synchronous FIFO-to-AXIS bridge. It consumes the bridge's raw 8-bit byte stream on its slave port. It hunts for a start-of-frame byte, reads a length byte, forwards the payload on an AXIS master port with `tlast` on the final byte, and verifies a trailing 8-bit additive checksum. Checksum failures are flagged on `tuser` with `tlast`. Dropped or corrupt frames are counted.

## Interface
- `sof_byte`, 8'hA5, start-of-frame marker searched for in HUNT.
- `cnt_width`, 16, width of the saturating drop counter.
- `aclk` in 1: single clock for all logic.
- `arstn` in 1: reset, synchronous and active-low.
- `s_axis_tdata` in 8: byte from the FT245 bridge master port.
- `s_axis_tvalid` in 1: input byte valid.
- `s_axis_tready` out 1: input byte accepted.
- `m_axis_tdata` out 8: payload byte.
- `m_axis_tvalid` out 1: output valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tlast` out 1: last payload byte of a frame.
- `m_axis_tuser` out 1: checksum mismatch. Meaningful only with `tlast`.
- `drop_count` out cnt_width: number of frames dropped for zero length or bad checksum.

## Operation
- Frame format:
  - `sof_byte`, then LEN (1..255), then LEN payload bytes, then CSUM.
  - CSUM = (LEN + all payload bytes) mod 256.
- A byte value equal to `sof_byte` inside the payload or CSUM is data; framing is purely length-based.
- Accept condition: `s_axis_tvalid & s_axis_tready`.
- `s_axis_tready = ~m_axis_tvalid | m_axis_tready` (combinational), in every state.
- State HUNT:
  - Accepted byte == `sof_byte` -> LEN.
  - Any other byte is discarded silently and the state stays HUNT; `drop_count` is unchanged.
- State LEN:
  - Byte == 0 -> HUNT, `drop_count` +1.
  - Otherwise: remaining <= byte, sum <= byte, first <= 1, -> PAYLOAD.
- State PAYLOAD, on each accepted byte:
  - sum <= sum + byte (8-bit wrap).
  - If first == 0, emit the held byte with tlast=0.
  - held <= byte; first <= 0; remaining <= remaining - 1.
  - remaining == 1 at accept -> CSUM.
- State CSUM, on the accepted byte:
  - Emit the held byte with tlast=1 and tuser = (byte != sum).
  - On mismatch, `drop_count` +1.
  - -> HUNT.
  - The frame is still delivered, flagged by `tuser`; the consumer decides whether to discard it.
- Emit means the output register loads tdata/tlast/tuser and `m_axis_tvalid` <= 1.
  - Emit is only possible on an accept, so the output register is always free or draining when an emit occurs.
  - `m_axis_tvalid` clears on `m_axis_tready` when no emit occurs in that cycle.
- `drop_count` saturates at all-ones and never wraps.
- Reset values (sampled on `aclk` while `arstn`=0):
  - state = HUNT.
  - `m_axis_tvalid` = 0, `m_axis_tdata` = 0, `m_axis_tlast` = 0, `m_axis_tuser` = 0.
  - held, sum, remaining, first = 0.
  - `drop_count` = 0.
  - `s_axis_tready` = 1 (follows from `m_axis_tvalid` = 0).
- Reset mid-frame: the partial frame is abandoned and no `tlast` is produced for it. The next accepted byte is treated in HUNT.

## Timing
- Payload byte k appears on `m_axis` the cycle after byte k+1 is accepted; for the last payload byte, that is the cycle after CSUM is accepted.
- Full throughput: one byte per cycle with `m_axis_tready` held high.
- Per-frame overhead: 3 non-emitting input bytes (SOF, LEN, and the first payload byte's hold slot). Output lags input by one accepted byte.
- While `m_axis_tvalid`=1 and `m_axis_tready`=0:
  - tdata, tlast and tuser are stable.
  - `s_axis_tready` = 0, and no internal state changes.
- `drop_count` updates one cycle after the accept of the offending LEN or CSUM byte.

## Test plan
- Good frame: in A5 03 11 22 33 69 with tready=1.
  - Out: 11, 22, 33; tlast only on 33; tuser=0; drop_count=0.
- Bad checksum: in A5 02 10 20 00.
  - Out: 10, 20; tlast and tuser=1 on 20; drop_count=1.
- Resync through garbage: in 00 FF 5A A5 01 7E 7F.
  - Out: single byte 7E with tlast=1, tuser=0; garbage produces no output.
- Zero length then A5 in payload: in A5 00 A5 02 A5 01 A8.
  - drop_count=1 after the first frame.
  - Out: A5, 01 (tlast, tuser=0). Sum = 02+A5+01 = A8.
- Backpressure: frame 1 with `m_axis_tready` toggling 1/0 each cycle and `s_axis_tvalid` held high.
  - Identical output sequence, no loss or duplication.
  - Data stable while stalled; `s_axis_tready` low whenever the output is stalled.
- Reset mid-payload: in A5 04 01 02, assert `arstn`=0 for 2 cycles, then send frame 1.
  - All outputs at reset values during reset.
  - No tlast from the aborted frame; frame 1 output correct; drop_count=0.

Source files
------------

// File: rtl/ft245_axis_deframer.sv
// ---------------------------------------------------------------------------
// ft245_axis_deframer
//
// Length-delimited frame decoder for the byte stream coming out of the FT245
// synchronous FIFO-to-AXIS bridge. Frame on the wire:
//   sof_byte, LEN (1..255), LEN payload bytes, CSUM = (LEN + payload) mod 256
// Payload bytes are forwarded on an AXIS master with tlast on the final byte.
// A checksum mismatch is flagged on tuser alongside tlast. Zero-length and
// bad-checksum frames bump a saturating drop counter.
//
// Parameters:
//   sof_byte      start-of-frame marker searched for while hunting
//   cnt_width     width of the saturating drop counter
// Ports:
//   aclk, arstn     clock, synchronous active-low reset
//   s_axis_*        8-bit byte stream in (tdata/tvalid/tready)
//   m_axis_*        payload out (tdata/tvalid/tready/tlast/tuser)
//   drop_count      frames dropped for zero length or bad checksum
// ---------------------------------------------------------------------------
module ft245_axis_deframer #(
  parameter logic [7:0] sof_byte  = 8'hA5,
  parameter int         cnt_width = 16
) (
  input  logic                 aclk,
  input  logic                 arstn,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic [cnt_width-1:0] drop_count
);

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_LEN     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CSUM    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [7:0]            r_held;
  logic [7:0]            r_sum;
  logic [7:0]            r_remaining;
  logic                  r_first;
  logic [7:0]            r_tdata;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic                  r_tuser;
  logic [cnt_width-1:0]  r_drop_count;

  logic                  w_accept;
  logic                  w_emit;
  logic                  w_emit_last;
  logic                  w_emit_user;
  logic                  w_drop;

  // Input is only taken when the output register is empty or draining this
  // cycle, so a stalled output freezes the whole pipeline.
  assign s_axis_tready = ~r_tvalid | m_axis_tready;
  assign w_accept      = s_axis_tvalid & s_axis_tready;

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;
  assign drop_count    = r_drop_count;

  // Next-state and per-accept control strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path through
    // the case leaves a signal unassigned, which would infer a latch.
    w_state_next = r_state;
    w_emit       = 1'b0;
    w_emit_last  = 1'b0;
    w_emit_user  = 1'b0;
    w_drop       = 1'b0;
    if (w_accept) begin
      unique case (r_state)
        S_HUNT: begin
          if (s_axis_tdata == sof_byte) w_state_next = S_LEN;
        end
        S_LEN: begin
          if (s_axis_tdata == 8'd0) begin
            w_state_next = S_HUNT;
            w_drop       = 1'b1;
          end else begin
            w_state_next = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          // The first payload byte only fills the hold slot; every later one
          // pushes the previous byte out, so the last byte waits for CSUM.
          w_emit = ~r_first;
          if (r_remaining == 8'd1) w_state_next = S_CSUM;
        end
        S_CSUM: begin
          w_emit       = 1'b1;
          w_emit_last  = 1'b1;
          w_emit_user  = (s_axis_tdata != r_sum);
          w_drop       = w_emit_user;
          w_state_next = S_HUNT;
        end
        default: w_state_next = S_HUNT;
      endcase
    end
  end

  // State register and datapath.
  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!arstn) begin
      r_state      <= S_HUNT;
      r_held       <= 8'd0;
      r_sum        <= 8'd0;
      r_remaining  <= 8'd0;
      r_first      <= 1'b0;
      r_tdata      <= 8'd0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_tuser      <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_accept) begin
        unique case (r_state)
          S_LEN: begin
            if (s_axis_tdata != 8'd0) begin
              r_remaining <= s_axis_tdata;
              r_sum       <= s_axis_tdata;
              r_first     <= 1'b1;
            end
          end
          S_PAYLOAD: begin
            r_sum       <= r_sum + s_axis_tdata;
            r_held      <= s_axis_tdata;
            r_first     <= 1'b0;
            r_remaining <= r_remaining - 8'd1;
          end
          default: ;
        endcase
      end

      if (w_emit) begin
        r_tdata  <= r_held;
        r_tlast  <= w_emit_last;
        r_tuser  <= w_emit_user;
        r_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        r_tvalid <= 1'b0;
      end

      if (w_drop && (r_drop_count != {cnt_width{1'b1}}))
        r_drop_count <= r_drop_count + {{(cnt_width-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_ft245_axis_deframer.sv
// ---------------------------------------------------------------------------
// Directed bench for ft245_axis_deframer. Output handshakes are collected by
// a monitor into a queue; the stimulus block compares that queue and the
// status outputs against hand-computed values after each frame.
// ---------------------------------------------------------------------------
module tb_ft245_axis_deframer;

  logic        aclk = 1'b0;
  logic        arstn = 1'b0;
  logic [7:0]  s_tdata = 8'd0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        m_tuser;
  logic [15:0] drop_count;

  logic        bp_mode = 1'b0;
  logic        tog = 1'b1;

  int n_assert = 0;
  int n_fail   = 0;

  logic [9:0]  q_out[$];
  int          stall_seen = 0;
  int          stall_err  = 0;
  logic        prev_stalled = 1'b0;
  logic [9:0]  prev_word = 10'd0;

  always #5 aclk = ~aclk;

  assign m_tready = bp_mode ? tog : 1'b1;

  always @(posedge aclk) begin
    #1;
    tog = ~tog;
  end

  ft245_axis_deframer #(
    .sof_byte  (8'hA5),
    .cnt_width (16)
  ) dut (
    .aclk          (aclk),
    .arstn         (arstn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .drop_count    (drop_count)
  );

  // Inputs change 1 time unit after posedge, so the mid-cycle view here is
  // exactly what the next rising edge will see.
  always @(negedge aclk) begin
    if (m_tvalid && m_tready) q_out.push_back({m_tdata, m_tlast, m_tuser});
    if (m_tvalid && !m_tready) begin
      stall_seen++;
      if (s_tready) stall_err++;
      if (prev_stalled && ({m_tdata, m_tlast, m_tuser} !== prev_word)) stall_err++;
    end
    prev_stalled = m_tvalid && !m_tready;
    prev_word    = {m_tdata, m_tlast, m_tuser};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] out_at(input int i);
    return (i < q_out.size()) ? q_out[i] : 10'h3FF;
  endfunction

  task automatic send(input logic [7:0] b);
    int t = 0;
    s_tdata  = b;
    s_tvalid = 1'b1;
    do begin
      @(negedge aclk);
      t++;
    end while (!s_tready && t < 50);
    check("accept", {31'd0, s_tready}, 32'd1);
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge aclk);
    #1;
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge aclk);
    #1;
    check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_tdata",  {24'd0, m_tdata}, 32'd0);
    check("rst_tlast",  {31'd0, m_tlast}, 32'd0);
    check("rst_tuser",  {31'd0, m_tuser}, 32'd0);
    check("rst_drop",   {16'd0, drop_count}, 32'd0);
    check("rst_sready", {31'd0, s_tready}, 32'd1);
    arstn = 1'b1;
    @(posedge aclk);
    #1;

    // Good frame at full throughput
    q_out.delete();
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    check("f1_lag_valid", {31'd0, m_tvalid}, 32'd1);
    check("f1_lag_data",  {24'd0, m_tdata}, 32'h33);
    check("f1_lag_last",  {31'd0, m_tlast}, 32'd1);
    drain();
    check("f1_count", q_out.size(), 32'd3);
    check("f1_b0", {22'd0, out_at(0)}, {22'd0, 8'h11, 1'b0, 1'b0});
    check("f1_b1", {22'd0, out_at(1)}, {22'd0, 8'h22, 1'b0, 1'b0});
    check("f1_b2", {22'd0, out_at(2)}, {22'd0, 8'h33, 1'b1, 1'b0});
    check("f1_drop", {16'd0, drop_count}, 32'd0);

    // Bad checksum
    q_out.delete();
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
    check("bad_drop_now", {16'd0, drop_count}, 32'd1);
    drain();
    check("bad_count", q_out.size(), 32'd2);
    check("bad_b0", {22'd0, out_at(0)}, {22'd0, 8'h10, 1'b0, 1'b0});
    check("bad_b1", {22'd0, out_at(1)}, {22'd0, 8'h20, 1'b1, 1'b1});

    // Resync through garbage
    q_out.delete();
    send(8'h00); send(8'hFF); send(8'h5A);
    check("garb_valid", {31'd0, m_tvalid}, 32'd0);
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    drain();
    check("sync_count", q_out.size(), 32'd1);
    check("sync_b0", {22'd0, out_at(0)}, {22'd0, 8'h7E, 1'b1, 1'b0});
    check("sync_drop", {16'd0, drop_count}, 32'd1);

    // Zero length, then sof_byte value inside the payload
    q_out.delete();
    send(8'hA5); send(8'h00);
    check("zl_drop", {16'd0, drop_count}, 32'd2);
    send(8'hA5); send(8'h02); send(8'hA5); send(8'h01); send(8'hA8);
    drain();
    check("zl_count", q_out.size(), 32'd2);
    check("zl_b0", {22'd0, out_at(0)}, {22'd0, 8'hA5, 1'b0, 1'b0});
    check("zl_b1", {22'd0, out_at(1)}, {22'd0, 8'h01, 1'b1, 1'b0});
    check("zl_drop_end", {16'd0, drop_count}, 32'd2);

    // Backpressure: downstream ready toggles every cycle
    q_out.delete();
    stall_seen = 0;
    stall_err  = 0;
    bp_mode    = 1'b1;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    drain();
    bp_mode = 1'b0;
    drain();
    check("bp_count", q_out.size(), 32'd3);
    check("bp_b0", {22'd0, out_at(0)}, {22'd0, 8'h11, 1'b0, 1'b0});
    check("bp_b1", {22'd0, out_at(1)}, {22'd0, 8'h22, 1'b0, 1'b0});
    check("bp_b2", {22'd0, out_at(2)}, {22'd0, 8'h33, 1'b1, 1'b0});
    check("bp_stalled", {31'd0, stall_seen > 0}, 32'd1);
    check("bp_stall_err", stall_err, 32'd0);

    // Reset in the middle of a payload
    q_out.delete();
    send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
    arstn = 1'b0;
    @(posedge aclk);
    #1;
    check("mid_rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("mid_rst_tdata",  {24'd0, m_tdata}, 32'd0);
    check("mid_rst_tlast",  {31'd0, m_tlast}, 32'd0);
    check("mid_rst_tuser",  {31'd0, m_tuser}, 32'd0);
    check("mid_rst_drop",   {16'd0, drop_count}, 32'd0);
    check("mid_rst_sready", {31'd0, s_tready}, 32'd1);
    @(posedge aclk);
    #1;
    arstn = 1'b1;
    begin
      int n_last = 0;
      foreach (q_out[i]) if (q_out[i][1]) n_last++;
      check("abort_no_tlast", n_last, 32'd0);
    end
    q_out.delete();
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    drain();
    check("post_count", q_out.size(), 32'd3);
    check("post_b0", {22'd0, out_at(0)}, {22'd0, 8'h11, 1'b0, 1'b0});
    check("post_b1", {22'd0, out_at(1)}, {22'd0, 8'h22, 1'b0, 1'b0});
    check("post_b2", {22'd0, out_at(2)}, {22'd0, 8'h33, 1'b1, 1'b0});
    check("post_drop", {16'd0, drop_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
